// File: rtl/h_dmux_stream_pkg.sv
// Shared defaults for the h_dmux_stream family and a constant clog2 used to size sel.
package h_dmux_stream_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  localparam int DEF_W     = 8;
  localparam int DEF_N     = 4;
  localparam int DEF_SEL_W = clog2(DEF_N);
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/h_dmux_slot.sv
// One-entry holding register for one output channel; a load beats a drain in the same cycle.
module h_dmux_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] q,
  output logic         free
);

  // A full slot is free in its drain cycle so back-to-back words see no bubble.
  assign free = !valid || ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/h_dmux_stream.sv
// Registered 1:N stream demultiplexer with broadcast, per-channel holding slots and a drop counter.
module h_dmux_stream
  import h_dmux_stream_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int N     = DEF_N,
  parameter int SEL_W = DEF_SEL_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic [SEL_W-1:0] sel,
  input  logic             bcast,
  output logic [N-1:0]     out_valid,
  input  logic [N-1:0]     out_ready,
  output logic [N*W-1:0]   out_data,
  output logic             drop_pulse,
  output logic [CNT_W-1:0] drop_cnt
);

  logic [N-1:0] free;
  logic [N-1:0] load;
  logic         sel_ok;
  logic         sel_free;
  logic         accept;
  logic         drop;

  always_comb begin
    sel_ok   = ({1'b0, sel} < (SEL_W+1)'(N));
    sel_free = 1'b0;
    for (int k = 0; k < N; k++)
      if (sel == SEL_W'(k)) sel_free = free[k];
    // Out-of-range words are always taken so they can be counted and dropped.
    if (!rst_n)     in_ready = 1'b0;
    else if (bcast) in_ready = &free;
    else            in_ready = sel_ok ? sel_free : 1'b1;
    accept = in_valid && in_ready;
    drop   = accept && !bcast && !sel_ok;
    for (int k = 0; k < N; k++)
      load[k] = accept && (bcast || (sel_ok && (sel == SEL_W'(k))));
  end

  for (genvar k = 0; k < N; k++) begin : g_slot
    h_dmux_slot #(.W(W)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[k]),
      .d     (in_data),
      .ready (out_ready[k]),
      .valid (out_valid[k]),
      .q     (out_data[k*W +: W]),
      .free  (free[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_pulse <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      drop_pulse <= drop;
      if (drop && !(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_h_dmux_stream.sv
// Directed and randomized checks of h_dmux_stream (N=4) plus an N=3 instance for out-of-range drops.
module tb_h_dmux_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, bcast;
  logic [7:0]  in_data;
  logic [1:0]  sel;
  logic [3:0]  out_valid, out_ready;
  logic [31:0] out_data;
  logic        drop_pulse;
  logic [7:0]  drop_cnt;

  logic        in_valid3, in_ready3, bcast3;
  logic [7:0]  in_data3;
  logic [1:0]  sel3;
  logic [2:0]  out_valid3, out_ready3;
  logic [23:0] out_data3;
  logic        drop_pulse3;
  logic [7:0]  drop_cnt3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  h_dmux_stream #(.W(8), .N(4), .SEL_W(2), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .sel(sel), .bcast(bcast), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .drop_pulse(drop_pulse),
    .drop_cnt(drop_cnt)
  );

  h_dmux_stream #(.W(8), .N(3), .SEL_W(2), .CNT_W(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_data(in_data3), .sel(sel3), .bcast(bcast3), .out_valid(out_valid3),
    .out_ready(out_ready3), .out_data(out_data3), .drop_pulse(drop_pulse3),
    .drop_cnt(drop_cnt3)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] sbq[4][$];
  logic [3:0] mv;
  logic [3:0] prev_stall;
  logic [31:0] prev_data;
  logic        acc;
  logic        exp_rdy;
  logic        ld;
  logic [7:0]  w;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; sel = '0; bcast = 1'b0; out_ready = 4'hF;
    in_valid3 = 1'b0; in_data3 = '0; sel3 = '0; bcast3 = 1'b0; out_ready3 = 3'h7;

    // 1: reset state and asynchronous reset mid-stream
    #1;
    chk("rst_vld", out_valid, 4'h0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_cnt", drop_cnt, 8'h0);
    chk("rst_rdy", in_ready, 1'b0);
    tick(); rst_n = 1'b1; tick();
    out_ready = 4'b1011; in_valid = 1'b1; in_data = 8'hA5; sel = 2'd2;
    tick(); in_valid = 1'b0;
    chk("pre_rst_vld", out_valid, 4'b0100);
    chk("pre_rst_d2", out_data[23:16], 8'hA5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_vld", out_valid, 4'h0);
    chk("async_rst_cnt", drop_cnt, 8'h0);
    chk("async_rst_rdy", in_ready, 1'b0);
    tick(); rst_n = 1'b1; out_ready = 4'hF; tick();
    chk("post_rst_vld", out_valid, 4'h0);

    // 2: unicast with ready consumer
    in_valid = 1'b1; in_data = 8'h3C; sel = 2'd1;
    #1 chk("uni_rdy", in_ready, 1'b1);
    tick(); in_valid = 1'b0;
    chk("uni_vld", out_valid, 4'b0010);
    chk("uni_d1", out_data[15:8], 8'h3C);
    tick();
    chk("uni_clr", out_valid, 4'h0);

    // 3: back-pressure on channel 0
    out_ready = 4'b1110; in_valid = 1'b1; in_data = 8'h11; sel = 2'd0;
    tick(); in_data = 8'h22;
    #1 chk("bp_rdy0", in_ready, 1'b0);
    chk("bp_vld", out_valid, 4'b0001);
    tick();
    chk("bp_hold", out_data[7:0], 8'h11);
    chk("bp_rdy1", in_ready, 1'b0);
    out_ready = 4'hF;
    #1 chk("bp_drain_rdy", in_ready, 1'b1);
    tick(); in_valid = 1'b0;
    chk("bp_nobubble_vld", out_valid, 4'b0001);
    chk("bp_nobubble_d", out_data[7:0], 8'h22);
    tick();
    chk("bp_clr", out_valid, 4'h0);

    // 4: broadcast blocked by stalled slot 3
    out_ready = 4'b0111; in_valid = 1'b1; in_data = 8'h99; sel = 2'd3;
    tick(); bcast = 1'b1; in_data = 8'h77; sel = 2'd0;
    #1 chk("bc_rdy0", in_ready, 1'b0);
    tick();
    chk("bc_rdy1", in_ready, 1'b0);
    chk("bc_vld_wait", out_valid, 4'b1000);
    chk("bc_d3_wait", out_data[31:24], 8'h99);
    out_ready = 4'hF;
    #1 chk("bc_rdy2", in_ready, 1'b1);
    tick(); in_valid = 1'b0; bcast = 1'b0;
    chk("bc_vld", out_valid, 4'hF);
    chk("bc_data", out_data, 32'h77777777);
    tick();
    chk("bc_clr", out_valid, 4'h0);
    chk("no_drops_n4", drop_cnt, 8'h0);

    // 5: out-of-range drops on the N=3 instance
    in_valid3 = 1'b1; in_data3 = 8'h5A; sel3 = 2'd3;
    #1 chk("oor_rdy", in_ready3, 1'b1);
    tick(); in_valid3 = 1'b0;
    chk("oor_pulse", drop_pulse3, 1'b1);
    chk("oor_cnt1", drop_cnt3, 8'd1);
    chk("oor_vld", out_valid3, 3'b000);
    tick();
    chk("oor_pulse_end", drop_pulse3, 1'b0);
    in_valid3 = 1'b1;
    for (int i = 0; i < 299; i++) tick();
    in_valid3 = 1'b0;
    chk("oor_sat", drop_cnt3, 8'd255);
    chk("oor_vld2", out_valid3, 3'b000);

    // 6: random traffic against a scoreboard and occupancy model
    mv = '0; prev_stall = '0; prev_data = '0; acc = 1'b1;
    tick();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      chk("rnd_vld", out_valid, mv);
      for (int k = 0; k < 4; k++)
        if (prev_stall[k]) chk("rnd_stable", out_data[k*8 +: 8], prev_data[k*8 +: 8]);
      if (!(in_valid && !acc)) begin
        in_valid = ($urandom_range(99) < 70);
        in_data  = 8'($urandom);
        sel      = 2'($urandom);
        bcast    = ($urandom_range(9) == 0);
      end
      out_ready = 4'($urandom);
      #1;
      exp_rdy = bcast ? &(~mv | out_ready) : (~mv[sel] | out_ready[sel]);
      chk("rnd_rdy", in_ready, exp_rdy);
      acc = in_valid && in_ready;
      for (int k = 0; k < 4; k++)
        if (out_valid[k] && out_ready[k]) begin
          if (sbq[k].size() == 0) chk("rnd_dup", 1'b1, 1'b0);
          else begin
            w = sbq[k].pop_front();
            chk("rnd_order", out_data[k*8 +: 8], w);
          end
        end
      for (int k = 0; k < 4; k++) begin
        ld = acc && (bcast || (sel == 2'(k)));
        if (ld) sbq[k].push_back(in_data);
        mv[k] = ld ? 1'b1 : (mv[k] && !out_ready[k]);
      end
      prev_stall = out_valid & ~out_ready;
      prev_data  = out_data;
      tick();
    end
    in_valid = 1'b0; bcast = 1'b0; out_ready = 4'hF;
    #1;
    for (int k = 0; k < 4; k++)
      if (out_valid[k] && sbq[k].size() != 0) begin
        w = sbq[k].pop_front();
        chk("rnd_tail", out_data[k*8 +: 8], w);
      end
    tick();
    chk("rnd_end_vld", out_valid, 4'h0);
    chk("rnd_loss", sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size(), 0);
    chk("rnd_no_drop", drop_cnt, 8'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
